// File: rtl/cipher_arbiter.sv
// Round-robin arbiter sharing one block-cipher core among NREQ requesters.
// Issues a start, watches the ready handshake with a watchdog and returns tagged results.
module cipher_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned DW   = 64,
    parameter int unsigned TMO  = 40
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din,
    output logic [NREQ-1:0]      gnt,
    output logic                 core_start,
    output logic [DW-1:0]        core_din,
    input  logic                 core_ready,
    input  logic [DW-1:0]        core_dout,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    output logic                 err,
    output logic                 busy
);

    localparam int unsigned WW = $clog2(TMO + 1);
    localparam int          NR = int'(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DELIVER
    } state_e;

    state_e            state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    sel_q;
    logic [WW-1:0]     wdog_q;
    logic [NREQ-1:0]   gnt_q;
    logic              start_q;
    logic [DW-1:0]     din_q;
    logic              vld_q;
    logic [IDW-1:0]    id_q;
    logic [DW-1:0]     data_q;
    logic              err_q;
    logic              busy_q;

    logic [DW-1:0]     din_a [NREQ];
    logic [IDW-1:0]    pick_c;
    logic              any_c;
    logic              wdog_exp_c;

    for (genvar g = 0; g < NR; g++) begin : g_din
        assign din_a[g] = din[g*DW +: DW];
    end

    // First requester at or after ptr; descending scan lets the earliest hit win.
    always_comb begin
        pick_c = ptr_q;
        for (int k = NR - 1; k >= 0; k--) begin
            if (req[IDW'((int'(ptr_q) + k) % NR)]) begin
                pick_c = IDW'((int'(ptr_q) + k) % NR);
            end
        end
    end

    assign any_c      = |req;
    // Counter reaches zero on this edge.
    assign wdog_exp_c = (wdog_q <= WW'(1));

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            wdog_q  <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            din_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_c) begin
                        sel_q   <= pick_c;
                        din_q   <= din_a[pick_c];
                        gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_c;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        wdog_q  <= WW'(TMO);
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog_q <= wdog_q - 1'b1;
                    if (!core_ready) begin
                        start_q <= 1'b0;
                        state_q <= S_BUSY;
                    end else if (wdog_exp_c) begin
                        start_q <= 1'b0;
                        data_q  <= '0;
                        id_q    <= sel_q;
                        vld_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DELIVER;
                    end
                end
                S_BUSY: begin
                    wdog_q <= wdog_q - 1'b1;
                    // A result arriving on the expiry cycle takes priority over the timeout.
                    if (core_ready) begin
                        data_q  <= core_dout;
                        id_q    <= sel_q;
                        vld_q   <= 1'b1;
                        state_q <= S_DELIVER;
                    end else if (wdog_exp_c) begin
                        data_q  <= '0;
                        id_q    <= sel_q;
                        vld_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    ptr_q   <= (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign core_start = start_q;
    assign core_din   = din_q;
    assign rsp_valid  = vld_q;
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cipher_arbiter.sv
// Self-checking bench for cipher_arbiter: behavioural core stand-in plus a
// round-robin/latency reference model, directed steps with random data.
module tb_cipher_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 64;
    localparam int TMO  = 40;

    logic                CK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  din;
    logic [NREQ-1:0]     gnt;
    logic                core_start;
    logic [DW-1:0]       core_din;
    logic                core_ready;
    logic [DW-1:0]       core_dout;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                err;
    logic                busy;

    logic [DW-1:0] blk [NREQ];
    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    always #5 CK = ~CK;

    assign din = {blk[3], blk[2], blk[1], blk[0]};

    cipher_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .TMO(TMO)) dut (
        .CK(CK), .RST(RST), .req(req), .din(din), .gnt(gnt),
        .core_start(core_start), .core_din(core_din),
        .core_ready(core_ready), .core_dout(core_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .err(err), .busy(busy)
    );

    // Stand-in cipher: 32-round Feistel-like mix.
    function automatic logic [63:0] cipher(input logic [63:0] x);
        logic [31:0] l, r, t;
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 32; i++) begin
            t = l ^ ({r[26:0], r[31:27]} + r + 32'h9E3779B9 * 32'(i));
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    // Core model: accepts start while ready, stays busy core_r cycles (or 50 when hung).
    int            core_r       = 32;
    logic          never_accept = 1'b0;
    logic          hang         = 1'b0;
    logic          rdy_q;
    int            cnt_q;
    logic [DW-1:0] res_q, lat_q;

    always @(posedge CK) begin
        if (RST) begin
            rdy_q <= 1'b1;
            cnt_q <= 0;
            res_q <= '0;
            lat_q <= '0;
        end else if (rdy_q) begin
            if (core_start && !never_accept) begin
                rdy_q <= 1'b0;
                cnt_q <= hang ? 50 : core_r;
                lat_q <= core_din;
            end
        end else begin
            cnt_q <= cnt_q - 1;
            if (cnt_q == 1) begin
                rdy_q <= 1'b1;
                if (!hang) res_q <= cipher(lat_q);
            end
        end
    end

    assign core_ready = rdy_q;
    assign core_dout  = res_q;

    int   rsp_cnt, start_cyc, start_runs;
    logic start_prev;

    always @(posedge CK) begin
        if (RST) begin
            rsp_cnt    <= 0;
            start_cyc  <= 0;
            start_runs <= 0;
            start_prev <= 1'b0;
        end else begin
            start_prev <= core_start;
            if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
            if (core_start) start_cyc <= start_cyc + 1;
            if (core_start && !start_prev) start_runs <= start_runs + 1;
        end
    end

    function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        m_ptr = 0;
    endtask

    // Waits for one response and checks it against the model; leaves the bench in IDLE.
    task automatic expect_op(input string tag, input int exp_id, input logic exp_err,
                             input int exp_cyc, output int obs_id);
        int              cyc;
        logic [IDW-1:0]  id;
        logic [DW-1:0]   data;
        logic            e;
        logic [NREQ-1:0] g;
        logic [DW-1:0]   exp_data;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            @(posedge CK);
            #1;
            cyc++;
        end
        id = rsp_id;
        data = rsp_data;
        e = err;
        g = gnt;
        exp_data = exp_err ? 64'd0 : cipher(blk[exp_id]);
        chk({tag, "_seen"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_id"}, 64'(id), 64'(exp_id));
        chk({tag, "_data"}, data, exp_data);
        chk({tag, "_err"}, 64'(e), 64'(exp_err));
        chk({tag, "_gnt"}, 64'(g), 64'd1 << exp_id);
        obs_id = int'(id);
        m_ptr = (exp_id + 1) % NREQ;
        tick(1);
    endtask

    initial begin
        int e, obs, prev;
        RST = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) blk[i] = '0;
        tick(2);

        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_core_din", core_din, 64'd0);
        RST = 1'b0;
        m_ptr = 0;

        // Single request, fixed block.
        for (int i = 0; i < NREQ; i++) blk[i] = {$urandom, $urandom};
        blk[1] = 64'h0123456789ABCDEF;
        req = 4'b0010;
        expect_op("t1", rr_pick(m_ptr, req), 1'b0, 35, obs);
        chk("t1_runs", 64'(start_runs), 64'd1);
        req = '0;

        // Full contention from reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) blk[i] = {$urandom, $urandom};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e = rr_pick(m_ptr, req);
            expect_op($sformatf("t2_op%0d", n), e, 1'b0, 35, obs);
        end
        chk("t2_rsp_cnt", 64'(rsp_cnt), 64'd5);

        // Fairness between 0 and 2.
        do_reset();
        req = 4'b0101;
        prev = -1;
        for (int n = 0; n < 4; n++) begin
            blk[0] = {$urandom, $urandom};
            blk[2] = {$urandom, $urandom};
            e = rr_pick(m_ptr, req);
            expect_op($sformatf("t3_op%0d", n), e, 1'b0, 35, obs);
            chk($sformatf("t3_alt%0d", n), 64'(obs == prev), 64'd0);
            prev = obs;
        end
        req = '0;

        // Result on the exact expiry cycle wins; one cycle later it times out.
        do_reset();
        core_r = 38;
        req = 4'b0100;
        expect_op("tb_r38", rr_pick(m_ptr, req), 1'b0, 1 + TMO, obs);
        core_r = 39;
        req = 4'b1000;
        expect_op("tb_r39", rr_pick(m_ptr, req), 1'b1, 1 + TMO, obs);
        core_r = 32;
        req = '0;

        // Core never accepts.
        do_reset();
        never_accept = 1'b1;
        req = 4'b0001;
        expect_op("t4", rr_pick(m_ptr, req), 1'b1, 1 + TMO, obs);
        chk("t4_start_cyc", 64'(start_cyc), 64'(TMO));
        chk("t4_busy", 64'(busy), 64'd0);
        never_accept = 1'b0;
        req = '0;

        // Core accepts then hangs; next queued requester still granted.
        do_reset();
        hang = 1'b1;
        req = 4'b1100;
        expect_op("t5", rr_pick(m_ptr, req), 1'b1, 1 + TMO, obs);
        e = rr_pick(m_ptr, req);
        tick(1);
        chk("t5_next_gnt", 64'(gnt), 64'd1 << e);
        chk("t5_next_start", 64'(core_start), 64'd1);
        hang = 1'b0;
        req = '0;

        // Reset in the middle of BUSY.
        do_reset();
        req = 4'b1000;
        tick(13);
        chk("t6_busy_before", 64'(busy), 64'd1);
        req = 4'b1001;
        RST = 1'b1;
        tick(1);
        chk("t6_gnt", 64'(gnt), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_start", 64'(core_start), 64'd0);
        chk("t6_valid", 64'(rsp_valid), 64'd0);
        chk("t6_din", core_din, 64'd0);
        RST = 1'b0;
        m_ptr = 0;
        expect_op("t6", rr_pick(m_ptr, req), 1'b0, 35, obs);
        chk("t6_rsp_cnt", 64'(rsp_cnt), 64'd1);
        req = '0;

        // Random request patterns and data.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NREQ; i++) blk[i] = {$urandom, $urandom};
            req = 4'($urandom_range(1, 15));
            e = rr_pick(m_ptr, req);
            expect_op($sformatf("t7_op%0d", n), e, 1'b0, 35, obs);
        end
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
